// File: rtl/tdc_ctrl_pkg.sv
// Shared state encoding, result flag positions and default widths for the
// TDC measurement controller.
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RUNNING = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CALC    = 3'd5,
    ST_PRESENT = 3'd6
  } tdc_state_e;

  localparam int FLG_OVR = 2;
  localparam int FLG_TMO = 1;
  localparam int FLG_UNF = 0;

  localparam int DEF_BIN_W = 5;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/tdc_interval_calc.sv
// Registered interval stage: coarse*2^BIN_W + start_bin - stop_bin, clamped
// at zero with an underflow flag, or forced to all-ones for a timeout.
module tdc_interval_calc
  import tdc_ctrl_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int RES_W = CNT_W + BIN_W + 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_force_max,
  input  logic [CNT_W-1:0] i_coarse,
  input  logic [BIN_W-1:0] i_bin_start,
  input  logic [BIN_W-1:0] i_bin_stop,
  output logic [RES_W-1:0] o_time,
  output logic             o_unf
);

  localparam int DW = RES_W + 1;

  logic signed [DW-1:0] w_diff;
  logic [RES_W:0]       w_res;

  // Packs {underflow, time}; negative intervals collapse to zero.
  function automatic logic [RES_W:0] clamp_diff(input logic signed [DW-1:0] d);
    if (d < 0) return {1'b1, {RES_W{1'b0}}};
    return {1'b0, d[RES_W-1:0]};
  endfunction

  assign w_diff = $signed({2'b00, i_coarse, {BIN_W{1'b0}}})
                + $signed({{(DW-BIN_W){1'b0}}, i_bin_start})
                - $signed({{(DW-BIN_W){1'b0}}, i_bin_stop});
  assign w_res  = clamp_diff(w_diff);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      o_time <= '0;
      o_unf  <= 1'b0;
    end else if (i_force_max) begin
      o_time <= '1;
      o_unf  <= 1'b0;
    end else if (i_load) begin
      {o_unf, o_time} <= w_res;
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Start/stop TDC measurement sequencer: arms the filters, waits out the
// encoder latency, computes the interval and hands it out on valid/ready.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int BIN_W    = DEF_BIN_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PIPE_LAT = 2,
  parameter int TMO_W    = 8,
  parameter int RES_W    = CNT_W + BIN_W + 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             continuous,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             start_valid,
  input  logic             stop_valid,
  input  logic [BIN_W-1:0] bin_start,
  input  logic [BIN_W-1:0] bin_stop,
  input  logic [CNT_W-1:0] coarse,
  output logic             tdc_arm,
  output logic             tdc_clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_time,
  output logic [2:0]       res_flags,
  output logic             busy
);

  tdc_state_e       r_state, w_next;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [2:0]       r_settle;
  logic             r_oneshot, r_ovr, r_flag_ovr, r_flag_tmo;
  logic [CNT_W-1:0] r_cap_coarse;
  logic [BIN_W-1:0] r_cap_start, r_cap_stop;
  logic             w_settle_last, w_tmo_hit, w_tmo_form, w_hit, w_accept, w_unf;

  assign w_settle_last = (r_settle == 3'(PIPE_LAT - 1));
  assign w_tmo_hit     = (tmo_limit != '0) && (r_tmo_cnt == tmo_limit - TMO_W'(1));
  assign w_tmo_form    = (r_state == ST_RUNNING) && enable && !stop_valid && w_tmo_hit;
  assign w_hit         = (start_valid || stop_valid) &&
                         (r_state inside {ST_SETTLE, ST_CALC, ST_PRESENT});
  assign w_accept      = (r_state == ST_PRESENT) && res_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (enable && (continuous || !r_oneshot)) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_ARMED;
      ST_ARMED:   if (!enable) w_next = ST_IDLE;
                  else if (start_valid) w_next = ST_RUNNING;
      ST_RUNNING: if (!enable) w_next = ST_IDLE;
                  else if (stop_valid) w_next = ST_SETTLE;
                  else if (w_tmo_hit) w_next = ST_PRESENT;
      ST_SETTLE:  if (w_settle_last) w_next = ST_CALC;
      ST_CALC:    w_next = ST_PRESENT;
      ST_PRESENT: if (res_ready) w_next = (continuous && enable) ? ST_CLEAR : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tdc_arm   = (r_state == ST_ARMED) || (r_state == ST_RUNNING);
    tdc_clear = (r_state == ST_CLEAR);
    res_valid = (r_state == ST_PRESENT);
    busy      = (r_state != ST_IDLE);
    res_flags          = '0;
    res_flags[FLG_OVR] = r_flag_ovr;
    res_flags[FLG_TMO] = r_flag_tmo;
    res_flags[FLG_UNF] = w_unf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oneshot  <= 1'b0;
      r_ovr      <= 1'b0;
      r_flag_ovr <= 1'b0;
      r_flag_tmo <= 1'b0;
      r_tmo_cnt  <= '0;
      r_settle   <= '0;
    end else begin
      if (!enable)                      r_oneshot <= 1'b0;
      else if (w_accept && !continuous) r_oneshot <= 1'b1;

      if (r_state == ST_ARMED)        r_tmo_cnt <= '0;
      else if (r_state == ST_RUNNING) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (r_state == ST_RUNNING)     r_settle <= '0;
      else if (r_state == ST_SETTLE) r_settle <= r_settle + 3'd1;

      // A forming result takes ownership of the pending overrun; later hits
      // start a fresh sticky for the result after it.
      if (r_state == ST_CALC) begin
        r_flag_ovr <= r_ovr || w_hit;
        r_flag_tmo <= 1'b0;
        r_ovr      <= 1'b0;
      end else if (w_tmo_form) begin
        r_flag_ovr <= r_ovr;
        r_flag_tmo <= 1'b1;
        r_ovr      <= 1'b0;
      end else begin
        if (r_state == ST_CLEAR) begin
          r_flag_ovr <= 1'b0;
          r_flag_tmo <= 1'b0;
        end
        if (w_hit) r_ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_SETTLE && w_settle_last) begin
      r_cap_coarse <= coarse;
      r_cap_start  <= bin_start;
      r_cap_stop   <= bin_stop;
    end
  end

  tdc_interval_calc #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W),
    .RES_W (RES_W)
  ) u_calc (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (r_state == ST_CLEAR),
    .i_load      (r_state == ST_CALC),
    .i_force_max (w_tmo_form),
    .i_coarse    (r_cap_coarse),
    .i_bin_start (r_cap_start),
    .i_bin_stop  (r_cap_stop),
    .o_time      (res_time),
    .o_unf       (w_unf)
  );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with a result scoreboard.
module tb_tdc_meas_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, continuous, start_valid, stop_valid, res_ready;
  logic [7:0] tmo_limit;
  logic [4:0] bin_start, bin_stop;
  logic [3:0] coarse;
  logic       tdc_arm, tdc_clear, res_valid, busy;
  logic [9:0] res_time;
  logic [2:0] res_flags;

  typedef struct packed {
    logic [9:0] t;
    logic [2:0] f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .continuous  (continuous),
    .tmo_limit   (tmo_limit),
    .start_valid (start_valid),
    .stop_valid  (stop_valid),
    .bin_start   (bin_start),
    .bin_stop    (bin_stop),
    .coarse      (coarse),
    .tdc_arm     (tdc_arm),
    .tdc_clear   (tdc_clear),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_time    (res_time),
    .res_flags   (res_flags),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arm"},   {31'd0, tdc_arm},   32'd0);
    chk({tag, "_clear"}, {31'd0, tdc_clear}, 32'd0);
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_time"},  {22'd0, res_time},  32'd0);
    chk({tag, "_flags"}, {29'd0, res_flags}, 32'd0);
  endtask

  // Wait for res_valid, check the latency, then pop and compare the result.
  task automatic wait_result(input string tag, input int exp_lat);
    int   n = 0;
    exp_t e;
    while (!res_valid && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    if (!res_valid) begin
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_time"},  {22'd0, res_time},  {22'd0, e.t});
      chk({tag, "_flags"}, {29'd0, res_flags}, {29'd0, e.f});
    end
  endtask

  task automatic measure(input string tag, input logic [3:0] c, input logic [4:0] bs,
                         input logic [4:0] bp, input logic [9:0] et, input logic [2:0] ef);
    coarse = c; bin_start = bs; bin_stop = bp;
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    tick(); tick();
    stop_valid = 1'b1; tick(); stop_valid = 1'b0;
    sb.push_back('{t: et, f: ef});
    wait_result(tag, 3);
  endtask

  task automatic rearm(input string tag);
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    chk({tag, "_clear_pulse"}, {31'd0, tdc_clear}, 32'd1);
    tick();
    chk({tag, "_armed"}, {30'd0, tdc_clear, tdc_arm}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; continuous = 1'b0; tmo_limit = 8'd0;
    start_valid = 1'b0; stop_valid = 1'b0; res_ready = 1'b1;
    bin_start = '0; bin_stop = '0; coarse = '0;
    tick(); tick();
    chk_idle("reset");

    // Single-shot normal measurement.
    reset = 1'b0; enable = 1'b1;
    tick();
    chk("t1_clear_pulse", {30'd0, tdc_clear, busy}, 32'd3);
    tick();
    chk("t1_armed", {30'd0, tdc_clear, tdc_arm}, 32'd1);
    stop_valid = 1'b1; tick(); stop_valid = 1'b0;
    chk("t1_lone_stop_ignored", {30'd0, tdc_arm, res_valid}, 32'd2);
    coarse = 4'd3; bin_start = 5'd10; bin_stop = 5'd4;
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    repeat (4) tick();
    stop_valid = 1'b1; tick(); stop_valid = 1'b0;
    chk("t1_settle_disarm", {31'd0, tdc_arm}, 32'd0);
    sb.push_back('{t: 10'd102, f: 3'b000});
    wait_result("t1", 3);
    tick();
    chk("t1_back_idle", {30'd0, busy, res_valid}, 32'd0);

    // Single-shot holds off re-arm while enable stays high.
    repeat (4) tick();
    chk("t6_no_rearm", {30'd0, busy, tdc_clear}, 32'd0);

    // Underflow clamp.
    rearm("t2");
    measure("t2", 4'd0, 5'd2, 5'd9, 10'd0, 3'b001);
    tick();

    // Timeout, then stop on the timeout cycle.
    tmo_limit = 8'd16;
    rearm("t3a");
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    sb.push_back('{t: 10'h3FF, f: 3'b010});
    wait_result("t3_tmo", 16);
    tick();
    rearm("t3b");
    coarse = 4'd2; bin_start = 5'd5; bin_stop = 5'd5;
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    repeat (15) tick();
    stop_valid = 1'b1; tick(); stop_valid = 1'b0;
    chk("t3_stop_wins", {30'd0, res_valid, tdc_arm}, 32'd0);
    sb.push_back('{t: 10'd64, f: 3'b000});
    wait_result("t3_stop", 3);
    tick();
    tmo_limit = 8'd0;

    // Continuous mode, back-pressure and overrun.
    continuous = 1'b1; res_ready = 1'b0;
    tick(); tick();
    chk("t4_armed", {31'd0, tdc_arm}, 32'd1);
    measure("t4a", 4'd1, 5'd7, 5'd3, 10'd36, 3'b000);
    for (int i = 0; i < 10; i++) begin
      start_valid = (i == 3);
      tick();
      chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t4_hold_time",  {22'd0, res_time},  32'd36);
      chk("t4_hold_flags", {29'd0, res_flags}, 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("t4_cont_clear", {31'd0, tdc_clear}, 32'd1);
    tick();
    measure("t4b", 4'd4, 5'd0, 5'd31, 10'd97, 3'b100);
    tick(); tick();
    measure("t4c", 4'd0, 5'd20, 5'd3, 10'd17, 3'b000);
    tick(); tick();

    // Reset during SETTLE discards the measurement.
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    tick();
    stop_valid = 1'b1; tick(); stop_valid = 1'b0;
    reset = 1'b1; tick();
    chk_idle("t5_reset");
    reset = 1'b0;
    tick(); tick();
    chk("t5_rearmed", {31'd0, tdc_arm}, 32'd1);

    // Enable dropped during RUNNING aborts with no result.
    start_valid = 1'b1; tick(); start_valid = 1'b0;
    tick();
    enable = 1'b0; tick();
    chk_idle("t5_abort");
    begin
      logic seen = 1'b0;
      repeat (6) begin
        tick();
        seen = seen | res_valid;
      end
      chk("t5_no_result", {31'd0, seen}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the start/stop TDC datapath.
- Arms the input/stop filters and tracks start_valid/stop_valid.
- Waits out the delay-line pipeline and thermometer-encoder latency, then captures the start/stop fine bins and the coarse count.
- Computes the time interval and presents it on a valid/ready result port.
- Sits between the TDC core and the readout logic, and provides timeout and overrun supervision.

Parameters:
BIN_W, 5, fine-bin width (32-tap delay line).
CNT_W, 4, coarse counter width.
PIPE_LAT, 2, cycles from stop_valid until bin_out_stop/bin_out_start are stable at encoder output (1..7).
TMO_W, 8, timeout counter width.
RES_W, CNT_W+BIN_W+1, result width.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  level; 1 = controller may arm.
continuous  in  1  1 = re-arm automatically after each result; 0 = single-shot, re-arm needs enable low then high.
tmo_limit  in  TMO_W  cycles allowed in RUNNING before timeout; 0 = timeout disabled.
start_valid  in  1  pulse from input filter: start hit accepted.
stop_valid  in  1  pulse from stop filter: stop hit accepted.
bin_start  in  BIN_W  encoded start fine bin.
bin_stop  in  BIN_W  encoded stop fine bin.
coarse  in  CNT_W  coarse clock count from counter.
tdc_arm  out  1  high while the TDC filters may accept hits (ARMED, RUNNING).
tdc_clear  out  1  one-cycle pulse that resets the TDC filters/counter.
res_valid  out  1  result handshake valid.
res_ready  in  1  result handshake ready.
res_time  out  RES_W  interval in fine-bin units.
res_flags  out  3  {overrun, timeout, underflow}.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: tdc_arm=0, tdc_clear=0, res_valid=0, res_time=0, res_flags=0, busy=0. The overrun sticky bit is cleared. State goes to IDLE.
- States: IDLE, CLEAR, ARMED, RUNNING, SETTLE, CALC, PRESENT.
- IDLE: on enable=1 (single-shot mode additionally requires the one-shot latch to be clear) -> CLEAR.
- CLEAR: tdc_clear=1 for exactly 1 cycle -> ARMED.
- ARMED: on start_valid -> RUNNING and reset the timeout counter. If stop_valid arrives with no start, ignore it. On enable=0 -> IDLE.
- RUNNING: timeout counter increments each cycle.
  - On stop_valid -> SETTLE with the settle counter at 0.
  - If tmo_limit!=0 and counter==tmo_limit-1 without a stop: set the timeout flag, res_time=all-ones -> PRESENT. tdc_clear is not pulsed in this case.
  - If stop_valid coincides with the timeout cycle, stop wins (no timeout).
- SETTLE: tdc_arm=0. Count PIPE_LAT cycles. On the last cycle, latch bin_start, bin_stop and coarse -> CALC.
- CALC (1 cycle): diff = {coarse,BIN_W'b0} + bin_start - bin_stop, computed in RES_W+1 signed bits.
  - If diff<0: res_time=0, underflow=1.
  - Otherwise res_time=diff[RES_W-1:0].
  - Go to PRESENT.
- Latency: stop_valid at cycle N -> capture at N+PIPE_LAT -> res_valid=1 from cycle N+PIPE_LAT+2.
- PRESENT: res_valid=1. res_time and res_flags are held stable until res_valid&res_ready.
  - On the handshake cycle: if continuous=1 and enable=1 -> CLEAR; otherwise -> IDLE and set the one-shot latch.
- One-shot latch: cleared when enable=0.
- Overrun:
  - start_valid or stop_valid seen during SETTLE, CALC or PRESENT sets the sticky overrun bit. The hit is dropped.
  - The bit is reported in res_flags of the next result and cleared when that result is accepted.
- enable deasserted mid-operation: ARMED and RUNNING abort to IDLE with no result. SETTLE, CALC and PRESENT complete normally.
- reset mid-operation: immediate return to reset values on the next edge. A pending result is discarded.
- busy=1 in every state except IDLE.

Decomposition:
- Package tdc_ctrl_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - flag bit indices OVR=2, TMO=1, UNF=0;
  - localparam defaults for BIN_W/CNT_W.
- Sub-module tdc_interval_calc: registered subtract/clamp stage producing res_time and the underflow flag from the latched coarse/bin_start/bin_stop.

Test Plan:
1. enable=1, continuous=0, start_valid, then 5 cycles later stop_valid; coarse=3, bin_start=10, bin_stop=4, res_ready=1 -> tdc_clear pulse, res_valid at stop+4 cycles, res_time=102, flags=000, then IDLE.
2. coarse=0, bin_start=2, bin_stop=9 -> res_time=0, flags=001.
3. tmo_limit=16, start_valid, no stop -> res_valid 16 cycles after start, res_time=all-ones (0x3FF), flags=010. Repeat with stop_valid on the 16th cycle -> normal result, timeout=0.
4. continuous=1, res_ready held 0 for 10 cycles while a start_valid arrives -> res_time/res_flags stable throughout. Accept -> next result carries overrun=1; the following result has overrun=0.
5. Assert reset during SETTLE, and separately drop enable during RUNNING -> all outputs 0 on the next cycle, state IDLE, no res_valid.
6. continuous=0, hold enable=1 after the result is accepted -> no re-arm. Toggle enable 0->1 -> new CLEAR pulse and ARMED.
